// File: rtl/rv32i_core_pkg.sv
// Shared types and constants for the RV32I front end.
// The fetch stage, its buffer and its bus interface all import this package.
package rv32i_core_pkg;

  localparam int unsigned IF_FIFO_DEPTH_DEFAULT = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_payload_t;

  typedef enum logic [1:0] {
    IF_IDLE,
    IF_REQ,
    IF_WAIT
  } if_state_e;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & ~32'h3;
  endfunction

endpackage

// File: rtl/rv32i_if_stage_if.sv
// Instruction-memory request/response bus and the fetch-to-decode handshake.
// The master modport is the fetch stage; the slave modport is memory plus decode.
interface rv32i_if_stage_if;
  import rv32i_core_pkg::*;

  logic           imem_req_o;
  logic [31:0]    imem_addr_o;
  logic           imem_gnt_i;
  logic           imem_rvalid_i;
  logic [31:0]    imem_rdata_i;
  logic           if_valid_o;
  if_id_payload_t if_payload_o;
  logic           id_ready_i;

  modport master (
    output imem_req_o, imem_addr_o, if_valid_o, if_payload_o,
    input  imem_gnt_i, imem_rvalid_i, imem_rdata_i, id_ready_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o, if_valid_o, if_payload_o,
    output imem_gnt_i, imem_rvalid_i, imem_rdata_i, id_ready_i
  );
endinterface

// File: rtl/rv32i_fetch_fifo.sv
// Small circular buffer of fetched {pc, instr} entries between fetch and decode.
// Push and pop together are accepted even when full; flush empties it in one cycle.
module rv32i_fetch_fifo
  import rv32i_core_pkg::*;
#(
  parameter int unsigned DEPTH = IF_FIFO_DEPTH_DEFAULT
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         push_i,
  input  if_id_payload_t               data_i,
  input  logic                         pop_i,
  input  logic                         flush_i,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output if_id_payload_t               head_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  if_id_payload_t   mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage needs no reset: the stage masks the head while the buffer is empty.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/rv32i_if_stage.sv
// RV32I instruction fetch: single-outstanding request engine feeding a small
// instruction buffer, with redirect flush and discard of in-flight responses.
module rv32i_if_stage
  import rv32i_core_pkg::*;
#(
  parameter logic [31:0] BOOT_ADDR  = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = IF_FIFO_DEPTH_DEFAULT
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    fetch_en_i,
  input  logic                    redirect_i,
  input  logic [31:0]             redirect_pc_i,
  rv32i_if_stage_if.master        bus
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  if_state_e        state_q, state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      req_pc_q, req_pc_d;
  logic             discard_q, discard_d;
  logic             push, pop;
  logic             fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count, eff_count;
  if_id_payload_t   push_data, fifo_head;

  always_comb begin
    state_d        = state_q;
    fetch_pc_d     = fetch_pc_q;
    req_pc_d       = req_pc_q;
    discard_d      = discard_q;
    push           = 1'b0;
    bus.imem_req_o = 1'b0;
    // A redirect empties the buffer this cycle, so issue decisions see it empty.
    eff_count      = redirect_i ? '0 : fifo_count;

    unique case (state_q)
      IF_IDLE: begin
        if (fetch_en_i && (redirect_i || !fifo_full)) state_d = IF_REQ;
      end
      IF_REQ: begin
        bus.imem_req_o = 1'b1;
        if (bus.imem_gnt_i) begin
          state_d    = IF_WAIT;
          req_pc_d   = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + 32'd4;
          discard_d  = redirect_i;
        end
      end
      IF_WAIT: begin
        if (bus.imem_rvalid_i) begin
          push      = !discard_q && !redirect_i;
          discard_d = 1'b0;
          // The completing response occupies a slot if it is kept.
          if (fetch_en_i && ((eff_count + CNT_W'(push)) < CNT_W'(FIFO_DEPTH)))
            state_d = IF_REQ;
          else
            state_d = IF_IDLE;
        end else if (redirect_i) begin
          discard_d = 1'b1;
        end
      end
      default: state_d = IF_IDLE;
    endcase

    if (redirect_i) fetch_pc_d = align_word(redirect_pc_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IF_IDLE;
      fetch_pc_q <= align_word(BOOT_ADDR);
      req_pc_q   <= '0;
      discard_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      discard_q  <= discard_d;
    end
  end

  assign push_data = '{pc: req_pc_q, instr: bus.imem_rdata_i};
  assign pop       = bus.if_valid_o && bus.id_ready_i;

  rv32i_fetch_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .data_i  (push_data),
    .pop_i   (pop),
    .flush_i (redirect_i),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count),
    .head_o  (fifo_head)
  );

  assign bus.imem_addr_o  = fetch_pc_q;
  assign bus.if_valid_o   = !fifo_empty && !redirect_i;
  assign bus.if_payload_o = fifo_empty ? '0 : fifo_head;

endmodule

// File: doc/rv32i_if_stage.md
RV32I_IF_STAGE -- requirements
Module: rv32i_if_stage

Interface
REQ-001 SHALL have parameter BOOT_ADDR, default 32'h0000_0000, PC loaded at reset.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2, fetched-instruction buffer entries; legal values 2 and 4.
REQ-003 SHALL use one clock and an asynchronous active-low reset.
REQ-004 clk_i  input  1  clock; all state on rising edge.
REQ-005 rst_ni  input  1  asynchronous active-low reset.
REQ-006 fetch_en_i  input  1  permits issuing new fetch requests.
REQ-007 redirect_i  input  1  branch/jump taken; flush and refetch.
REQ-008 redirect_pc_i  input  32  redirect target; bits [1:0] treated as zero.
REQ-009 imem_req_o  output  1  instruction memory request.
REQ-010 imem_addr_o  output  32  request address, word aligned.
REQ-011 imem_gnt_i  input  1  request accepted this cycle.
REQ-012 imem_rvalid_i  input  1  read data valid.
REQ-013 imem_rdata_i  input  32  instruction word.
REQ-014 if_valid_o  output  1  if_payload_o valid toward decode.
REQ-015 if_payload_o  output  if_id_payload_t  {pc, instr}.
REQ-016 id_ready_i  input  1  decode accepts payload this cycle.

Function
REQ-017 FSM states SHALL be IDLE (no request), REQ (imem_req_o=1, awaiting gnt), WAIT (granted, awaiting rvalid).
REQ-018 IDLE->REQ SHALL occur when fetch_en_i=1 and FIFO free entries exceed zero after counting the outstanding request.
REQ-019 REQ->WAIT on imem_gnt_i=1; WAIT->REQ on imem_rvalid_i if issue condition holds, else WAIT->IDLE.
REQ-020 At most one request SHALL be outstanding; imem_req_o SHALL be 0 in IDLE and WAIT.
REQ-021 imem_addr_o SHALL equal fetch_pc; fetch_pc increments by 4 on each grant.
REQ-022 In REQ without gnt, imem_addr_o SHALL stay stable unless redirect_i=1.
REQ-023 Accepted response SHALL be written to FIFO tail with the PC of its granted request; if_valid_o rises the cycle after imem_rvalid_i (latency 1).
REQ-024 if_valid_o SHALL equal FIFO non-empty AND NOT redirect_i; payload is FIFO head.
REQ-025 FIFO pop SHALL occur when if_valid_o && id_ready_i; simultaneous push and pop when full SHALL be allowed.
REQ-026 Payload at head SHALL be held stable while if_valid_o=1 and id_ready_i=0.
REQ-027 redirect_i SHALL empty the FIFO and load fetch_pc=redirect_pc_i next cycle.
REQ-028 redirect_i in WAIT, or coincident with imem_gnt_i, SHALL set a discard flag; next imem_rvalid_i is dropped, flag cleared.
REQ-029 redirect_i in REQ without gnt SHALL retarget; the following cycle imem_addr_o=redirect target.
REQ-030 redirect_i coincident with imem_rvalid_i SHALL drop that response.
REQ-031 fetch_en_i=0 SHALL stop new requests only; outstanding response still completes.
REQ-032 fetch_pc SHALL wrap from 32'hFFFF_FFFC to 32'h0000_0000 without flag.

Reset
REQ-033 On rst_ni=0: state IDLE, fetch_pc=BOOT_ADDR, FIFO empty, discard flag 0, imem_req_o=0, if_valid_o=0, if_payload_o='0.
REQ-034 First request SHALL assert the first cycle after reset release when fetch_en_i=1.
REQ-035 Reset mid-transaction SHALL abandon outstanding request; responses during reset ignored.

Structure
REQ-036 if_id_payload_t, if_state_e enum and IF_FIFO_DEPTH_DEFAULT SHALL reside in rv32i_core_pkg.
REQ-037 FIFO SHALL be sub-module rv32i_fetch_fifo (push, pop, flush, full, empty, count).

Verification
REQ-038 Reset release, fetch_en_i=1, gnt immediate, rvalid next cycle, rdata=32'h00500093 -> addr 0x0, if_valid_o with pc=0x0, instr=32'h00500093.
REQ-039 id_ready_i=0 for 5 cycles, zero-wait memory, DEPTH=2 -> exactly 2 entries fetched (0x0, 0x4), imem_req_o low, payload held at pc=0x0.
REQ-040 redirect_i to 0x100 while WAIT on 0x8 -> 0x8 response dropped, next imem_addr_o=0x100, first if_valid_o pc=0x100.
REQ-041 redirect_i to 0x203 coincident with gnt -> granted response discarded, next request addr=0x200.
REQ-042 gnt delayed 3 cycles at addr 0x40 -> addr stable 0x40 all cycles, one entry pc=0x40.
REQ-043 rst_ni asserted during WAIT -> all outputs reset values within same cycle; next fetch from BOOT_ADDR.
